// File: rtl/apb_stream_pkg.sv
// Shared beat-kind codes and FSM state encoding for the APB slave stream bridge.
package apb_stream_pkg;

    localparam logic [1:0] KIND_WR_ADDR = 2'd0;
    localparam logic [1:0] KIND_WR_DATA = 2'd1;
    localparam logic [1:0] KIND_RD_ADDR = 2'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_ADDR = 3'd1,
        SEND_DATA = 3'd2,
        WAIT_CPL  = 3'd3,
        RESP      = 3'd4
    } state_t;

endpackage

// File: rtl/apb_cpl_timeout.sv
// Completion watchdog: counts cycles while enabled, flags the last allowed cycle.
module apb_cpl_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_cnt <= '0;
                else if (i_clear)
                    r_cnt <= '0;
                else if (i_enable)
                    r_cnt <= r_cnt + CNT_W'(1);
            end

            // Count starts at 0 on the first waiting cycle, so TIMEOUT-1 is the last one.
            assign o_expired = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/apb_slave_stream_bridge.sv
// APB slave that turns each transfer into address/data beats on a valid/ready
// stream and waits for a peripheral completion (or timeout) before pready.
module apb_slave_stream_bridge
    import apb_stream_pkg::*;
#(
    parameter int ID      = 1,
    parameter int SEL_W   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEL_W-1:0]  psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [1:0]        m_kind,
    output logic [DATA_W-1:0] m_data,
    input  logic              cpl_valid,
    input  logic              cpl_err,
    input  logic [DATA_W-1:0] cpl_data
);

    state_t            r_state, w_state_nxt;
    logic              r_write, w_write_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_pready, w_pready_nxt;
    logic              r_pslverr, w_pslverr_nxt;
    logic [DATA_W-1:0] r_prdata, w_prdata_nxt;
    logic              r_m_valid, w_m_valid_nxt;
    logic [1:0]        r_m_kind, w_m_kind_nxt;
    logic [DATA_W-1:0] r_m_data, w_m_data_nxt;
    logic              w_sel;
    logic              w_expired;

    assign w_sel = (psel == SEL_W'(ID));

    apb_cpl_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state != WAIT_CPL),
        .i_enable  (r_state == WAIT_CPL),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_m_valid <= 1'b0;
            r_m_kind  <= KIND_WR_ADDR;
            r_m_data  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_write   <= w_write_nxt;
            r_wdata   <= w_wdata_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_prdata  <= w_prdata_nxt;
            r_m_valid <= w_m_valid_nxt;
            r_m_kind  <= w_m_kind_nxt;
            r_m_data  <= w_m_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_write_nxt   = r_write;
        w_wdata_nxt   = r_wdata;
        w_pready_nxt  = r_pready;
        w_pslverr_nxt = r_pslverr;
        w_prdata_nxt  = r_prdata;
        w_m_valid_nxt = r_m_valid;
        w_m_kind_nxt  = r_m_kind;
        w_m_data_nxt  = r_m_data;

        case (r_state)
            IDLE: begin
                w_pready_nxt  = 1'b0;
                w_pslverr_nxt = 1'b0;
                w_prdata_nxt  = '0;
                w_m_valid_nxt = 1'b0;
                w_m_kind_nxt  = KIND_WR_ADDR;
                w_m_data_nxt  = '0;
                if (w_sel && penable && !r_pready) begin
                    w_write_nxt   = pwrite;
                    w_wdata_nxt   = pwdata;
                    w_m_kind_nxt  = pwrite ? KIND_WR_ADDR : KIND_RD_ADDR;
                    w_m_data_nxt  = DATA_W'(paddr);
                    w_m_valid_nxt = 1'b1;
                    w_state_nxt   = SEND_ADDR;
                end
            end
            SEND_ADDR: begin
                if (m_ready) begin
                    if (r_write) begin
                        w_m_kind_nxt = KIND_WR_DATA;
                        w_m_data_nxt = r_wdata;
                        w_state_nxt  = SEND_DATA;
                    end else begin
                        w_m_valid_nxt = 1'b0;
                        w_state_nxt   = WAIT_CPL;
                    end
                end
            end
            SEND_DATA: begin
                if (m_ready) begin
                    w_m_valid_nxt = 1'b0;
                    w_state_nxt   = WAIT_CPL;
                end
            end
            WAIT_CPL: begin
                // A completion arriving on the expiry cycle still counts as on time.
                if (cpl_valid) begin
                    w_pready_nxt  = 1'b1;
                    w_pslverr_nxt = cpl_err;
                    w_prdata_nxt  = r_write ? '0 : cpl_data;
                    w_state_nxt   = RESP;
                end else if (w_expired) begin
                    w_pready_nxt  = 1'b1;
                    w_pslverr_nxt = 1'b1;
                    w_prdata_nxt  = '0;
                    w_state_nxt   = RESP;
                end
            end
            RESP: begin
                w_pready_nxt  = 1'b0;
                w_pslverr_nxt = 1'b0;
                w_prdata_nxt  = '0;
                w_state_nxt   = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign m_valid = r_m_valid;
    assign m_kind  = r_m_kind;
    assign m_data  = r_m_data;

endmodule

// File: tb/tb_apb_slave_stream_bridge.sv
// Scoreboard bench: stimulus queues expected beats/responses, a monitor checks them.
module tb_apb_slave_stream_bridge;

    localparam int         TO   = 8;
    localparam logic [1:0] MYID = 2'd1;

    typedef struct { logic [1:0] kind; logic [31:0] data; } beat_t;
    typedef struct { logic err; logic [31:0] data; int lat; } rsp_t;
    typedef struct { logic wr; int as; int ds; int k; logic err; logic [31:0] cdata; } plan_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  psel = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    wire  [31:0] prdata;
    wire         pready, pslverr, m_valid;
    logic        m_ready = 1'b0;
    wire  [1:0]  m_kind;
    wire  [31:0] m_data;
    logic        per_cpl = 1'b0;
    logic        stray_cpl = 1'b0;
    logic        cpl_err = 1'b0;
    logic [31:0] cpl_data = '0;
    wire         cpl_valid = per_cpl | stray_cpl;

    beat_t exp_beats[$];
    rsp_t  exp_rsp[$];
    plan_t plans[$];
    int    n_pass = 0;
    int    n_total = 0;

    always #5 clk = ~clk;

    apb_slave_stream_bridge #(
        .ID(1), .SEL_W(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .m_valid(m_valid), .m_ready(m_ready), .m_kind(m_kind),
        .m_data(m_data), .cpl_valid(cpl_valid), .cpl_err(cpl_err), .cpl_data(cpl_data)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        n_total++;
        $display("FAIL %s: event not expected / not seen", nm);
    endtask

    // Monitor: samples 2ns after each falling edge, after all drivers settled.
    initial begin
        bit          hold_pend;
        bit          post_pend;
        logic [1:0]  hk;
        logic [31:0] hd;
        int          lat;
        beat_t       b;
        rsp_t        r;
        hold_pend = 0; post_pend = 0; lat = 0; hk = '0; hd = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold_pend = 0; post_pend = 0; lat = 0;
            end else begin
                if (post_pend) begin
                    chk("post_resp_zero", {31'd0, pready, pslverr, prdata}, 64'd0);
                    post_pend = 0;
                end
                if (hold_pend) begin
                    chk("hold_valid", 64'(m_valid), 64'd1);
                    chk("hold_beat", {30'd0, m_kind, m_data}, {30'd0, hk, hd});
                end
                hold_pend = m_valid && !m_ready;
                hk = m_kind;
                hd = m_data;
                if (m_valid && m_ready) begin
                    if (exp_beats.size() == 0) fail_now("unexpected_beat");
                    else begin
                        b = exp_beats.pop_front();
                        chk("beat_kind", 64'(m_kind), 64'(b.kind));
                        chk("beat_data", 64'(m_data), 64'(b.data));
                    end
                end
                if (psel == MYID && penable && !pready) lat++;
                if (pready) begin
                    if (exp_rsp.size() == 0) fail_now("unexpected_pready");
                    else begin
                        r = exp_rsp.pop_front();
                        chk("pslverr", 64'(pslverr), 64'(r.err));
                        chk("prdata", 64'(prdata), 64'(r.data));
                        chk("latency", 64'(lat), 64'(r.lat));
                    end
                    lat = 0;
                    post_pend = 1;
                end
            end
        end
    end

    // Peripheral: accepts beats after the planned stalls, then returns a completion.
    initial begin
        plan_t p;
        int    nb, st, w;
        forever begin
            @(negedge clk);
            if (plans.size() != 0) begin
                p = plans.pop_front();
                nb = p.wr ? 2 : 1;
                for (int b = 0; b < nb; b++) begin
                    st = (b == 0) ? p.as : p.ds;
                    w = 0;
                    while (!m_valid && w < 200) begin
                        @(negedge clk);
                        w++;
                    end
                    if (!m_valid) begin
                        fail_now("periph_wait_valid");
                        break;
                    end
                    m_ready = 1'b0;
                    repeat (st) @(negedge clk);
                    m_ready = 1'b1;
                    @(negedge clk);
                    m_ready = 1'b0;
                end
                if (p.k < 16) begin
                    repeat (p.k) @(negedge clk);
                    cpl_err  = p.err;
                    cpl_data = p.cdata;
                    per_cpl  = 1'b1;
                    @(negedge clk);
                    per_cpl  = 1'b0;
                end
            end
        end
    end

    // Reference: beats and response follow from the transfer and the peripheral plan.
    task automatic push_expect(input logic wr, input logic [31:0] a, input logic [31:0] d,
                               input int as, input int ds, input int k, input logic err,
                               input logic [31:0] cd, input bit want_rsp);
        plan_t p;
        rsp_t  r;
        int    wait_cyc;
        exp_beats.push_back('{wr ? 2'd0 : 2'd2, a});
        if (wr) exp_beats.push_back('{2'd1, d});
        if (k < TO) begin
            wait_cyc = k + 1;
            r.err  = err;
            r.data = wr ? 32'd0 : cd;
        end else begin
            wait_cyc = TO;
            r.err  = 1'b1;
            r.data = 32'd0;
        end
        r.lat = 2 + as + (wr ? 1 + ds : 0) + wait_cyc;
        if (want_rsp) exp_rsp.push_back(r);
        p = '{wr, as, ds, k, err, cd};
        plans.push_back(p);
    endtask

    task automatic start_apb(input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = MYID; pwrite = wr; paddr = a; pwdata = d; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        // Capture has happened; scrambling the bus must not disturb the transfer.
        paddr = $urandom; pwdata = $urandom; pwrite = ~wr;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int as, input int ds, input int k, input logic err,
                        input logic [31:0] cd);
        int w;
        push_expect(wr, a, d, as, ds, k, err, cd, 1'b1);
        start_apb(wr, a, d);
        w = 0;
        while (!pready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!pready) fail_now("pready_timeout");
        @(negedge clk);
        psel = '0; penable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {29'd0, pready, pslverr, m_valid}, 64'd0);
        chk("reset_kind_data", {30'd0, m_kind, m_data}, 64'd0);
        chk("reset_prdata", 64'(prdata), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        xfer(1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0);
        xfer(0, 32'h24, 32'h0, 0, 0, 0, 0, 32'h12345678);
        xfer(1, 32'h10, 32'hDEADBEEF, 0, 5, 0, 0, 32'h0);
        xfer(1, 32'h40, 32'hCAFEF00D, 0, 0, 100, 0, 32'h0);
        xfer(0, 32'h44, 32'h0, 2, 0, 100, 0, 32'h55AA55AA);
        xfer(1, 32'h48, 32'h01020304, 0, 0, TO - 1, 0, 32'h0);
        xfer(0, 32'h4C, 32'h0, 1, 0, TO - 1, 1, 32'h89ABCDEF);

        // Foreign select must not start anything.
        @(negedge clk);
        psel = 2'd2; pwrite = 1'b1; paddr = 32'h80; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("foreign_sel_idle", {62'd0, m_valid, pready}, 64'd0);
        end
        psel = '0; penable = 1'b0;

        // Stray completion while idle is ignored.
        @(negedge clk);
        stray_cpl = 1'b1;
        @(negedge clk);
        stray_cpl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stray_cpl_idle", {62'd0, m_valid, pready}, 64'd0);
        end
        xfer(0, 32'h24, 32'h0, 0, 0, 2, 0, 32'hA5A5F00F);

        // Reset while the data beat is stalled.
        push_expect(1, 32'h60, 32'h77777777, 0, 20, 0, 0, 32'h0, 1'b0);
        start_apb(1, 32'h60, 32'h77777777);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_mid_valid_pready", {62'd0, m_valid, pready}, 64'd0);
        chk("reset_mid_beat", {30'd0, m_kind, m_data}, 64'd0);
        exp_beats.delete();
        exp_rsp.delete();
        psel = '0; penable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pready || m_valid) bad++;
        end
        chk("post_reset_quiet", 64'(bad), 64'd0);
        xfer(1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0);

        for (int i = 0; i < 25; i++) begin
            xfer(1'($urandom_range(0, 1)), $urandom, $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), $urandom);
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_beats.size() + exp_rsp.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/apb_slave_stream_bridge.md
Name: apb_slave_stream_bridge

Overview:
- Parametrised next-generation APB slave controller. It bridges APB write and read transfers onto a peripheral-side valid/ready beat stream and a completion channel.
- Adds what the previous slave lacked: parametrised widths and select ID, stream back-pressure, read support, a completion timeout, and pslverr.
- Sits between the APB master controller and the peripheral controller/FIFO, one instance per selected slave.

Parameters:
- ID, 1, psel value that selects this slave.
- SEL_W, 2, width of psel.
- ADDR_W, 32, paddr width; must be <= DATA_W.
- DATA_W, 32, pwdata/prdata/beat data width.
- TIMEOUT, 255, completion timeout in cycles; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- psel  input  SEL_W  slave select; this slave is selected when psel == ID.
- penable  input  1  APB access phase.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  transfer address.
- pwdata  input  DATA_W  write data.
- prdata  output  DATA_W  read data, valid while pready is high.
- pready  output  1  one-cycle transfer-complete pulse.
- pslverr  output  1  error flag, valid while pready is high.
- m_valid  output  1  beat valid to peripheral.
- m_ready  input  1  peripheral accepts beat.
- m_kind  output  2  beat type: 0 = WR_ADDR, 1 = WR_DATA, 2 = RD_ADDR.
- m_data  output  DATA_W  beat payload; address beats are zero-extended.
- cpl_valid  input  1  peripheral completion strobe.
- cpl_err  input  1  completion error, sampled with cpl_valid.
- cpl_data  input  DATA_W  read data, sampled with cpl_valid.

Behaviour:
- Reset (async, rst_n = 0): state IDLE; pready, pslverr, m_valid = 0; m_kind, m_data, prdata = 0; timeout counter = 0. Reset asserted mid-transfer abandons the transfer; no pready is issued for it.
- States: IDLE, SEND_ADDR, SEND_DATA, WAIT_CPL, RESP.
- IDLE:
  - When psel == ID and penable == 1 and pready == 0: register paddr, pwdata and pwrite.
  - Load m_kind = WR_ADDR or RD_ADDR, m_data = paddr, m_valid = 1; go to SEND_ADDR.
  - Any other psel value: stay in IDLE, all outputs held at 0.
- SEND_ADDR:
  - m_valid held high; m_kind and m_data held stable until m_valid && m_ready.
  - On handshake, write: m_kind = WR_DATA, m_data = stored pwdata, stay valid, go to SEND_DATA. Read: m_valid = 0, go to WAIT_CPL.
- SEND_DATA: hold the beat until handshake, then m_valid = 0, go to WAIT_CPL.
- Back-pressure: no beat is ever dropped; m_ready low for N cycles stretches the state by N cycles.
- WAIT_CPL:
  - Counter clears on entry and increments each cycle.
  - On cpl_valid: pslverr = cpl_err; prdata = cpl_data for reads, 0 for writes; go to RESP.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: pslverr = 1, prdata = 0, go to RESP.
  - If cpl_valid and timeout fall in the same cycle, cpl_valid wins.
- cpl_valid received in any state other than WAIT_CPL is ignored.
- RESP:
  - pready = 1 for exactly one cycle; pslverr and prdata valid in that cycle.
  - Next cycle: pready = 0, pslverr = 0, prdata = 0, go to IDLE.
  - The pready == 0 qualifier in IDLE blocks re-triggering on the cycle pready drops.
- Minimum write latency, penable seen to pready: 4 cycles with m_ready tied high and cpl_valid returned 1 cycle after the data beat.
- Changes to paddr, pwdata or pwrite after capture have no effect on the transfer in flight.

Decomposition:
- Package apb_stream_pkg holds:
  - beat-kind constants KIND_WR_ADDR = 2'd0, KIND_WR_DATA = 2'd1, KIND_RD_ADDR = 2'd2;
  - the state encoding IDLE..RESP.
- Sub-module apb_cpl_timeout: counter of width $clog2(TIMEOUT+1) with inputs clear/enable and output expired. Tied off when TIMEOUT == 0.

Test Plan:
- Write with m_ready = 1, cpl 1 cycle later: paddr = 0x10, pwdata = 0xDEADBEEF, psel = 1 -> beats (0, 0x10) then (1, 0xDEADBEEF); pready pulses once for 1 cycle, pslverr = 0.
- Read: paddr = 0x24, cpl_data = 0x12345678 -> one beat (2, 0x24); prdata = 0x12345678 while pready = 1, and 0 on the next cycle.
- Back-pressure: m_ready low 5 cycles during the WR_DATA beat -> m_kind and m_data held unchanged for 5 cycles, exactly one accepted WR_DATA beat, pready 5 cycles later than the baseline.
- Timeout: TIMEOUT = 8, cpl_valid never asserted -> pready with pslverr = 1 exactly 8 cycles after entering WAIT_CPL. Same run with cpl_valid on the expiry cycle and cpl_err = 0 -> pslverr = 0.
- Select and stray completion: psel = 2 with penable -> no beats, no pready. cpl_valid pulsed while in IDLE -> ignored; a following transfer completes normally.
- Reset: rst_n low during SEND_DATA -> m_valid and pready drop immediately. After release: IDLE, no pready, and the next write completes normally.
